// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, burst-locking arbiter sharing one UART byte
//            transmitter among NUM_REQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       grant_active,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam int TC_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [ID_W-1:0] c_last_id   = ID_W'(NUM_REQ - 1);
    localparam logic [BC_W-1:0] c_burst_end = BC_W'(MAX_BURST - 1);
    localparam logic [TC_W-1:0] c_idle_end  = TC_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_grant_id;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [BC_W-1:0]   r_burst_cnt;
    logic [TC_W-1:0]   r_idle_cnt;

    logic              w_any_valid;
    logic [ID_W-1:0]   w_pick;
    logic              w_g_valid;
    logic              w_g_last;
    logic [DATA_W-1:0] w_g_data;
    logic              w_hs;
    logic              w_release;
    logic [ID_W-1:0]   w_next_ptr;

    // Indices at/after the pointer outrank those before it; lowest index wins within each group.
    always_comb begin
        w_pick = r_rr_ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) < r_rr_ptr)) begin
                w_pick = ID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_W'(i) >= r_rr_ptr)) begin
                w_pick = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == ID_W'(i)) begin
                w_g_valid    = req_valid[i];
                w_g_last     = req_last[i];
                w_g_data     = req_data[i*DATA_W +: DATA_W];
                req_ready[i] = grant_active & tx_ready;
            end
        end
    end

    assign w_any_valid  = |req_valid;
    assign grant_active = (r_state == ST_GRANTED);
    assign grant_id     = r_grant_id;
    assign tx_valid     = grant_active & w_g_valid;
    assign tx_data      = tx_valid ? w_g_data : '0;
    assign w_hs         = tx_valid & tx_ready;
    assign w_next_ptr   = (r_grant_id == c_last_id) ? '0 : r_grant_id + 1'b1;
    assign w_release    = grant_active &
                          ((w_hs & (w_g_last | (r_burst_cnt == c_burst_end))) |
                           (~w_g_valid & (r_idle_cnt == c_idle_end)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_burst_cnt <= '0;
                    r_idle_cnt  <= '0;
                    if (w_any_valid) begin
                        r_grant_id <= w_pick;
                        r_state    <= ST_GRANTED;
                    end
                end
                ST_GRANTED: begin
                    if (w_release) begin
                        r_state     <= ST_IDLE;
                        r_rr_ptr    <= w_next_ptr;
                        r_burst_cnt <= '0;
                        r_idle_cnt  <= '0;
                    end else if (w_hs) begin
                        if (r_burst_cnt < c_burst_end) begin
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                        end
                        r_idle_cnt <= '0;
                    end else if (!w_g_valid) begin
                        // A stalled-but-valid requester never advances the idle count.
                        if (r_idle_cnt < c_idle_end) begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
